// File: rtl/exec_sequencer.sv
// exec_sequencer: execute/writeback stage in front of a 32 x DATA_W register file.
//
// Accepts one decoded instruction per valid/ready handshake, reads both source
// operands from the register file, computes a DATA_W-bit ALU result (MUL is a
// DATA_W-cycle shift-add) and issues a single writeback strobe plus zero/carry
// flag update.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   instr_valid / instr_ready       instruction handshake (ready only in IDLE)
//   instr_op, instr_rs1/rs2/rd      decoded opcode and register fields
//   raddr1, raddr2                  registered regfile read addresses
//   rdata1, rdata2                  regfile read data (combinational from raddr)
//   waddr, wdata, write_en          writeback port, write_en is a 1-cycle strobe
//   zero_flag, carry_flag           flags of the last retired result
//   done                            1-cycle pulse in the retire (WB) cycle
//
// Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 MUL, 111 NOP.
module exec_sequencer #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic [ADDR_W-1:0] instr_rd,
  output logic [ADDR_W-1:0] raddr1,
  output logic [ADDR_W-1:0] raddr2,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              write_en,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              done
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_MUL,
    S_WB
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_MUL = 3'b110,
    OP_NOP = 3'b111
  } op_e;

  state_e              state_q, state_d;
  op_e                 op_q;
  logic [ADDR_W-1:0]   rd_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [2*DATA_W-1:0] acc_q, mul_acc_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   res_q;

  logic                accept;
  logic                finish;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_cy;

  logic [DATA_W:0]     add_w, sub_w;
  logic [2*DATA_W-1:0] shl_w;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // finish marks the edge that enters WB: result, writeback and flags load there.
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    accept      = 1'b0;
    finish      = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          accept  = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ:  state_d = (op_q == OP_MUL) ? S_MUL : S_EXEC;
      S_EXEC: begin
        finish  = 1'b1;
        state_d = S_WB;
      end
      S_MUL: begin
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          finish  = 1'b1;
          state_d = S_WB;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  // One shift-add step: add A<<cnt when multiplier bit cnt is set.
  assign mul_acc_d = acc_q + (b_q[cnt_q] ? ({{DATA_W{1'b0}}, a_q} << cnt_q) : '0);

  assign add_w = {1'b0, a_q} + {1'b0, b_q};
  assign sub_w = {1'b0, a_q} - {1'b0, b_q};
  assign shl_w = {{DATA_W{1'b0}}, a_q} << b_q[1:0];

  always_comb begin
    alu_res = '0;
    alu_cy  = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = add_w[DATA_W-1:0];
        alu_cy  = add_w[DATA_W];
      end
      OP_SUB: begin
        alu_res = sub_w[DATA_W-1:0];
        alu_cy  = sub_w[DATA_W];
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SHL: begin
        alu_res = shl_w[DATA_W-1:0];
        alu_cy  = |shl_w[2*DATA_W-1:DATA_W];
      end
      // Only consulted on the last MUL step, so the final partial product is
      // taken from the accumulator's next value.
      OP_MUL: begin
        alu_res = mul_acc_d[DATA_W-1:0];
        alu_cy  = |mul_acc_d[2*DATA_W-1:DATA_W];
      end
      OP_NOP:  alu_res = res_q;
      default: alu_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath / writeback registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_ADD;
      rd_q       <= '0;
      raddr1     <= '0;
      raddr2     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      res_q      <= '0;
      waddr      <= '0;
      write_en   <= 1'b0;
      done       <= 1'b0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else begin
      write_en <= 1'b0;
      done     <= 1'b0;

      if (accept) begin
        op_q   <= op_e'(instr_op);
        rd_q   <= instr_rd;
        raddr1 <= instr_rs1;
        raddr2 <= instr_rs2;
      end

      if (state_q == S_READ) begin
        a_q   <= rdata1;
        b_q   <= rdata2;
        acc_q <= '0;
        cnt_q <= '0;
      end

      if (state_q == S_MUL) begin
        acc_q <= mul_acc_d;
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (finish) begin
        done <= 1'b1;
        // NOP retires without touching result, writeback port or flags.
        if (op_q != OP_NOP) begin
          res_q      <= alu_res;
          waddr      <= rd_q;
          write_en   <= 1'b1;
          zero_flag  <= (alu_res == '0);
          carry_flag <= alu_cy;
        end
      end
    end
  end

  assign wdata = res_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: directed bench for exec_sequencer with a 32x4 register
// file model attached to the read/write ports.
module tb_exec_sequencer;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst_n;
  logic              instr_valid;
  logic              instr_ready;
  logic [2:0]        instr_op;
  logic [ADDR_W-1:0] instr_rs1, instr_rs2, instr_rd;
  logic [ADDR_W-1:0] raddr1, raddr2, waddr;
  logic [DATA_W-1:0] rdata1, rdata2, wdata;
  logic              write_en, zero_flag, carry_flag, done;

  int checks   = 0;
  int failures = 0;

  // Register file: preload port driven by the bench, write port by the DUT.
  logic [DATA_W-1:0] regs [32];
  logic              tb_we;
  logic [ADDR_W-1:0] tb_wa;
  logic [DATA_W-1:0] tb_wd;

  always @(posedge clk) begin
    if (tb_we)         regs[tb_wa] <= tb_wd;
    else if (write_en) regs[waddr] <= wdata;
  end
  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

  exec_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_rd(instr_rd),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .waddr(waddr), .wdata(wdata), .write_en(write_en),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Results captured by wait_done.
  int          r_lat;
  logic        r_we, r_zero, r_carry, r_done_after, r_we_after;
  logic [4:0]  r_waddr;
  logic [3:0]  r_wdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [3:0] d);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    tick();
    tb_we = 1'b0;
  endtask

  // Present an instruction, wait (bounded) for ready, let the accept edge pass.
  task automatic issue(input logic [2:0] op, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d);
    int n;
    instr_op = op; instr_rs1 = s1; instr_rs2 = s2; instr_rd = d;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin
      tick();
      n++;
    end
    if (!instr_ready) chk("ready_timeout", 32'(instr_ready), 32'd1);
    tick();
    instr_valid = 1'b0;
  endtask

  // Wait for done; r_lat counts cycles from the handshake cycle to the WB cycle.
  task automatic wait_done();
    int   n;
    logic got;
    n = 0; got = 1'b0;
    while (n < 20 && !got) begin
      tick();
      n++;
      if (done) got = 1'b1;
    end
    chk("done_seen", 32'(got), 32'd1);
    r_lat   = n + 1;
    r_we    = write_en;
    r_waddr = waddr;
    r_wdata = wdata;
    r_zero  = zero_flag;
    r_carry = carry_flag;
    tick();
    r_done_after = done;
    r_we_after   = write_en;
  endtask

  int we_seen;

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr_op = '0;
    instr_rs1 = '0; instr_rs2 = '0; instr_rd = '0;
    tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_we", 32'(write_en), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_zero", 32'(zero_flag), 32'd0);
    chk("rst_carry", 32'(carry_flag), 32'd0);
    chk("rst_raddr1", 32'(raddr1), 32'd0);
    chk("rst_raddr2", 32'(raddr2), 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);

    // ADD 9+8 = 17 -> 1, carry
    preload(5'd1, 4'd9); preload(5'd2, 4'd8);
    issue(3'b000, 5'd1, 5'd2, 5'd3);
    chk("add_busy", 32'(instr_ready), 32'd0);
    chk("add_raddr1", 32'(raddr1), 32'd1);
    chk("add_raddr2", 32'(raddr2), 32'd2);
    wait_done();
    chk("add_lat", 32'(r_lat), 32'd3);
    chk("add_we", 32'(r_we), 32'd1);
    chk("add_waddr", 32'(r_waddr), 32'd3);
    chk("add_wdata", 32'(r_wdata), 32'd1);
    chk("add_carry", 32'(r_carry), 32'd1);
    chk("add_zero", 32'(r_zero), 32'd0);
    chk("add_done_once", 32'(r_done_after), 32'd0);
    chk("add_we_once", 32'(r_we_after), 32'd0);
    chk("add_regfile", 32'(regs[3]), 32'd1);

    // SUB 2-5 = 13, borrow
    preload(5'd1, 4'd2); preload(5'd2, 4'd5);
    issue(3'b001, 5'd1, 5'd2, 5'd7);
    wait_done();
    chk("sub_wdata", 32'(r_wdata), 32'd13);
    chk("sub_carry", 32'(r_carry), 32'd1);
    chk("sub_zero", 32'(r_zero), 32'd0);

    // SUB 7-7 = 0
    preload(5'd4, 4'd7);
    issue(3'b001, 5'd4, 5'd4, 5'd8);
    wait_done();
    chk("subz_wdata", 32'(r_wdata), 32'd0);
    chk("subz_zero", 32'(r_zero), 32'd1);
    chk("subz_carry", 32'(r_carry), 32'd0);
    chk("raddr1_hold", 32'(raddr1), 32'd4);
    chk("waddr_hold", 32'(waddr), 32'd8);

    // MUL 7*3 = 21 -> 5, carry
    preload(5'd1, 4'd7); preload(5'd2, 4'd3);
    issue(3'b110, 5'd1, 5'd2, 5'd9);
    wait_done();
    chk("mul_lat", 32'(r_lat), 32'd6);
    chk("mul_waddr", 32'(r_waddr), 32'd9);
    chk("mul_wdata", 32'(r_wdata), 32'd5);
    chk("mul_carry", 32'(r_carry), 32'd1);
    chk("mul_done_once", 32'(r_done_after), 32'd0);

    // MUL 3*5 = 15
    preload(5'd1, 4'd3); preload(5'd2, 4'd5);
    issue(3'b110, 5'd1, 5'd2, 5'd11);
    wait_done();
    chk("mul2_wdata", 32'(r_wdata), 32'd15);
    chk("mul2_carry", 32'(r_carry), 32'd0);
    chk("mul2_zero", 32'(r_zero), 32'd0);

    // AND 5&A = 0, OR 5|A = F
    preload(5'd1, 4'h5); preload(5'd2, 4'hA);
    issue(3'b010, 5'd1, 5'd2, 5'd12);
    wait_done();
    chk("and_wdata", 32'(r_wdata), 32'd0);
    chk("and_zero", 32'(r_zero), 32'd1);
    issue(3'b011, 5'd1, 5'd2, 5'd13);
    wait_done();
    chk("or_wdata", 32'(r_wdata), 32'hF);
    chk("or_carry", 32'(r_carry), 32'd0);

    // Back-to-back dependency: ADD r5=1+2, then XOR r6=r5^r1 held valid
    preload(5'd1, 4'd1); preload(5'd2, 4'd2);
    issue(3'b000, 5'd1, 5'd2, 5'd5);
    instr_op = 3'b100; instr_rs1 = 5'd5; instr_rs2 = 5'd1; instr_rd = 5'd6;
    instr_valid = 1'b1;
    chk("b2b_read_ready", 32'(instr_ready), 32'd0);
    tick();
    chk("b2b_exec_ready", 32'(instr_ready), 32'd0);
    tick();
    chk("b2b_wb1_done", 32'(done), 32'd1);
    chk("b2b_wb1_waddr", 32'(waddr), 32'd5);
    chk("b2b_wb1_wdata", 32'(wdata), 32'd3);
    chk("b2b_wb1_ready", 32'(instr_ready), 32'd0);
    tick();
    chk("b2b_idle_ready", 32'(instr_ready), 32'd1);
    tick();
    instr_valid = 1'b0;
    chk("b2b_accept2", 32'(instr_ready), 32'd0);
    chk("b2b_raddr1", 32'(raddr1), 32'd5);
    chk("b2b_raddr2", 32'(raddr2), 32'd1);
    tick(); tick();
    chk("b2b_wb2_we", 32'(write_en), 32'd1);
    chk("b2b_wb2_waddr", 32'(waddr), 32'd6);
    chk("b2b_wb2_wdata", 32'(wdata), 32'd2);
    tick();
    chk("b2b_regfile", 32'(regs[6]), 32'd2);

    // rd = 0 is an ordinary destination
    issue(3'b000, 5'd1, 5'd1, 5'd0);
    wait_done();
    chk("r0_waddr", 32'(r_waddr), 32'd0);
    chk("r0_we", 32'(r_we), 32'd1);
    chk("r0_regfile", 32'(regs[0]), 32'd2);

    // SHL B<<2 = 0x2C -> C, shifted-out bits nonzero
    preload(5'd1, 4'hB); preload(5'd2, 4'd2);
    issue(3'b101, 5'd1, 5'd2, 5'd10);
    wait_done();
    chk("shl_wdata", 32'(r_wdata), 32'hC);
    chk("shl_carry", 32'(r_carry), 32'd1);
    chk("shl_zero", 32'(r_zero), 32'd0);

    // NOP: retires, no write, flags and writeback port unchanged
    issue(3'b111, 5'd1, 5'd2, 5'd14);
    wait_done();
    chk("nop_lat", 32'(r_lat), 32'd3);
    chk("nop_we", 32'(r_we), 32'd0);
    chk("nop_carry", 32'(r_carry), 32'd1);
    chk("nop_zero", 32'(r_zero), 32'd0);
    chk("nop_waddr_hold", 32'(r_waddr), 32'd10);
    chk("nop_wdata_hold", 32'(r_wdata), 32'hC);

    // Reset in the middle of a MUL
    issue(3'b110, 5'd1, 5'd2, 5'd15);
    tick(); tick();
    chk("mid_busy", 32'(instr_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(instr_ready), 32'd1);
    chk("arst_carry", 32'(carry_flag), 32'd0);
    chk("arst_waddr", 32'(waddr), 32'd0);
    chk("arst_wdata", 32'(wdata), 32'd0);
    chk("arst_raddr1", 32'(raddr1), 32'd0);
    chk("arst_we", 32'(write_en), 32'd0);
    tick();
    rst_n = 1'b1;
    we_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (write_en || done) we_seen++;
    end
    chk("arst_no_wb", 32'(we_seen), 32'd0);
    chk("arst_regfile", 32'(regs[15] === 4'd6), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Execute/writeback stage sitting directly in front of the 32x4 register file.
- Accepts one decoded instruction at a time over a valid/ready handshake.
- Drives the regfile read addresses, latches both operands, and computes a 4-bit ALU result; MUL is iterative.
- Issues exactly one writeback (waddr/wdata/write_en) per writing instruction and maintains zero/carry flags.

Parameters:
- DATA_W, 4: operand/result width; must match regfile data width.
- ADDR_W, 5: register address width; must match regfile address width.

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- instr_valid  input  1  instruction present
- instr_ready  output  1  block can accept an instruction
- instr_op  input  3  opcode
- instr_rs1  input  ADDR_W  source register 1
- instr_rs2  input  ADDR_W  source register 2
- instr_rd  input  ADDR_W  destination register
- raddr1  output  ADDR_W  regfile read address 1
- raddr2  output  ADDR_W  regfile read address 2
- rdata1  input  DATA_W  regfile read data 1 (combinational from raddr1)
- rdata2  input  DATA_W  regfile read data 2
- waddr  output  ADDR_W  writeback address
- wdata  output  DATA_W  writeback data
- write_en  output  1  writeback strobe, one cycle
- zero_flag  output  1  last result == 0
- carry_flag  output  1  last carry/borrow/overflow
- done  output  1  one-cycle pulse at instruction retire

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; instr_ready=1.
  - raddr1, raddr2, waddr, wdata, operand regs, result reg = 0.
  - write_en, done, zero_flag, carry_flag = 0.
  - Reset mid-instruction aborts it; no write_en is issued.
- States: IDLE, READ, EXEC, MUL, WB.
- IDLE:
  - instr_ready=1 only in IDLE.
  - On instr_valid & instr_ready, capture op/rd, load raddr1=rs1 and raddr2=rs2 (registered), go to READ.
- READ: at the edge, latch A=rdata1 and B=rdata2. Go to MUL if op=110, else EXEC.
- EXEC (1 cycle): compute result and carry into registers, go to WB.
  - 000 ADD: A+B; carry = bit 4.
  - 001 SUB: A-B mod 16; carry = 1 iff A<B (borrow).
  - 010 AND, 011 OR, 100 XOR: carry=0.
  - 101 SHL: A<<B[1:0], truncated to 4 bits; carry = OR of bits shifted out.
  - 111 NOP: no result; flags unchanged.
- MUL:
  - Shift-add over exactly DATA_W (4) cycles, using an 8-bit accumulator and a 2-bit counter.
  - result = product[3:0]; carry = |product[7:4].
  - Then go to WB.
- WB (1 cycle):
  - write_en=1, waddr=rd, wdata=result, done=1, for every op except NOP.
  - NOP: write_en=0, done=1.
  - zero_flag and carry_flag update at entry to WB, i.e. they are visible in the same cycle as write_en.
  - Next state IDLE.
- Latency, accept edge to write_en high:
  - Non-MUL: 3 cycles (IDLE→READ→EXEC→WB).
  - MUL: 6 cycles.
  - The regfile captures data on the edge ending WB.
- Throughput: one instruction per 4 cycles (7 for MUL). Because instr_ready returns only in IDLE, a dependent instruction always reads the written value; no forwarding is required.
- rd=0 is written like any other register; r0 is not hardwired.
- raddr1/raddr2 hold their last value outside READ; waddr/wdata hold their last value when write_en=0.
- instr_valid while busy is ignored; the instruction is not consumed.
- All arithmetic is unsigned, modulo 2^DATA_W.

Test Plan:
- Reset: assert rst_n=0 mid-MUL → all outputs 0 immediately, instr_ready=1, no write_en after release.
- ADD with r1=9, r2=8, rd=3 → write_en exactly 3 cycles after accept, waddr=3, wdata=1, carry=1, zero=0; done pulses once.
- SUB with r1=2, r2=5 → wdata=13, carry=1. SUB with r4=7, r4 (rs1=rs2=4) → wdata=0, zero=1, carry=0.
- MUL with r1=7, r2=3 → write_en 6 cycles after accept, wdata=5, carry=1. MUL 3×5 → wdata=15, carry=0.
- Back-to-back dependency: ADD r5=r1+r2 (1+2), then XOR r6=r5^r1 held valid continuously → second accept only after WB, wdata=2; instr_valid during busy is not consumed.
- SHL r1=0xB by 2 → wdata=0xC, carry=1. NOP → done=1, write_en=0, flags unchanged from the previous instruction.
